// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single regfile write port among NUM_REQ
// writeback sources, with a one-cycle registered write and read-port bypass flags.

module regfile_wb_lane #(
    parameter int AW      = 5,
    parameter bit LOCK_R0 = 1'b1
) (
    input  logic          valid,
    input  logic [AW-1:0] addr,
    input  logic          block,
    output logic          eligible,
    output logic          commit
);
    assign eligible = valid & ~block;
    // r0 writes are still consumed so the requester drains, but never land
    assign commit   = ~(LOCK_R0 && (addr == '0));
endmodule

module regfile_wb_arbiter #(
    parameter int DATAPATH_WIDTH     = 64,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int NUM_REQ            = 4,
    parameter bit LOCK_R0            = 1'b1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_REQ-1:0]                     req_valid,
    input  logic [NUM_REQ*REGFILE_ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATAPATH_WIDTH-1:0]      req_data,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic                                   wr_hold,
    output logic [REGFILE_ADDR_WIDTH-1:0]          wr_addr_out,
    output logic [DATAPATH_WIDTH-1:0]              wr_data_out,
    output logic                                   wr_en_out,
    input  logic [REGFILE_ADDR_WIDTH-1:0]          rd1_addr,
    input  logic [REGFILE_ADDR_WIDTH-1:0]          rd2_addr,
    output logic                                   byp1_hit,
    output logic                                   byp2_hit,
    output logic [DATAPATH_WIDTH-1:0]              byp_data
);
    localparam int AW = REGFILE_ADDR_WIDTH;
    localparam int DW = DATAPATH_WIDTH;
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_req_t;

    wb_req_t [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    commit;
    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         grant_idx;
    logic                  grant_vld;
    logic                  wr_en_q;

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_lane
            assign req[g].addr = req_addr[g*AW +: AW];
            assign req[g].data = req_data[g*DW +: DW];
            regfile_wb_lane #(.AW(AW), .LOCK_R0(LOCK_R0)) u_lane (
                .valid    (req_valid[g]),
                .addr     (req[g].addr),
                .block    (reset | wr_hold),
                .eligible (eligible[g]),
                .commit   (commit[g])
            );
        end
    endgenerate

    // First eligible requester at or after rr_ptr, wrapping around
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!grant_vld && eligible[(int'(rr_ptr) + off) % NUM_REQ]) begin
                grant_vld = 1'b1;
                grant_idx = PW'((int'(rr_ptr) + off) % NUM_REQ);
            end
        end
        req_ready = '0;
        if (grant_vld) req_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_out <= '0;
            wr_data_out <= '0;
        end else begin
            wr_en_q <= grant_vld & commit[grant_idx];
            if (grant_vld) begin
                rr_ptr      <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
                wr_addr_out <= req[grant_idx].addr;
                wr_data_out <= req[grant_idx].data;
            end
        end
    end

    // Gating with reset keeps an in-flight write out of the regfile when reset lands mid-write
    assign wr_en_out = wr_en_q & ~reset;
    assign byp1_hit  = wr_en_out & (rd1_addr == wr_addr_out);
    assign byp2_hit  = wr_en_out & (rd2_addr == wr_addr_out);
    assign byp_data  = wr_data_out;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus randomized bench for regfile_wb_arbiter against a queue/array
// level model of round-robin grant, one-cycle write latency and bypass.

module tb_regfile_wb_arbiter;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            wr_hold = 1'b0;
    logic [AW-1:0]   wr_addr_out;
    logic [DW-1:0]   wr_data_out;
    logic            wr_en_out;
    logic [AW-1:0]   rd1_addr = '0;
    logic [AW-1:0]   rd2_addr = '0;
    logic            byp1_hit, byp2_hit;
    logic [DW-1:0]   byp_data;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATAPATH_WIDTH(DW), .REGFILE_ADDR_WIDTH(AW),
                         .NUM_REQ(N), .LOCK_R0(1'b1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .wr_hold(wr_hold),
        .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out), .wr_en_out(wr_en_out),
        .rd1_addr(rd1_addr), .rd2_addr(rd2_addr), .byp1_hit(byp1_hit),
        .byp2_hit(byp2_hit), .byp_data(byp_data)
    );

    // Regfile as seen by the DUT's write port
    logic [DW-1:0] rf [32] = '{default: '0};
    always @(posedge clk) if (wr_en_out) rf[wr_addr_out] <= wr_data_out;

    int total = 0;
    int bad   = 0;

    // Requester state and model
    logic          v [N];
    logic [AW-1:0] a [N];
    logic [DW-1:0] d [N];
    int            m_ptr = 0;
    logic          m_en = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic [DW-1:0] mrf [32] = '{default: '0};
    int            last_grant;
    logic [N-1:0]  last_rdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = v[i];
            req_addr[i*AW +: AW]  = a[i];
            req_data[i*DW +: DW]  = d[i];
        end
    endtask

    // One clock cycle: drive, check against model, clock, advance model
    task automatic cycle();
        int k;
        logic en_now;
        apply();
        #1;
        k = -1;
        if (!reset && !wr_hold)
            for (int o = 0; o < N; o++)
                if (k < 0 && v[(m_ptr + o) % N]) k = (m_ptr + o) % N;
        en_now = m_en && !reset;
        chk("ready", 64'(req_ready), (k >= 0) ? 64'(1) << k : 64'(0));
        chk("wr_en", 64'(wr_en_out), 64'(en_now));
        chk("wr_addr", 64'(wr_addr_out), 64'(m_addr));
        chk("wr_data", wr_data_out, m_data);
        chk("byp1", 64'(byp1_hit), 64'(en_now && rd1_addr == m_addr));
        chk("byp2", 64'(byp2_hit), 64'(en_now && rd2_addr == m_addr));
        chk("byp_data", byp_data, m_data);
        last_grant = k;
        last_rdy   = req_ready;
        @(posedge clk);
        if (en_now) mrf[m_addr] = m_data;
        if (reset) begin
            m_ptr = 0; m_en = 1'b0; m_addr = '0; m_data = '0;
        end else if (k >= 0) begin
            m_ptr  = (k + 1) % N;
            m_en   = (a[k] != '0);
            m_addr = a[k];
            m_data = d[k];
        end else begin
            m_en = 1'b0;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin v[i] = 1'b0; a[i] = '0; d[i] = '0; end

        // Reset cycle: no grant even with requests pending
        v[0] = 1'b1; a[0] = 5'd9;
        cycle();
        chk("rst_rdy", 64'(last_rdy), 64'(0));
        reset = 1'b0;

        // All four valid, held: grants 0,1,2,3,0
        for (int i = 0; i < N; i++) begin v[i] = 1'b1; a[i] = AW'(i + 1); d[i] = 64'(100 + i); end
        for (int s = 0; s < 5; s++) begin
            cycle();
            chk("t1_seq", 64'(last_rdy), 64'(1) << (s % N));
        end
        for (int i = 0; i < N; i++) v[i] = 1'b0;
        cycle();

        // Lone requester 2
        v[2] = 1'b1; a[2] = 5'd7; d[2] = 64'hDEAD;
        cycle();
        chk("t2_rdy", 64'(last_rdy), 64'b0100);
        v[2] = 1'b0;
        chk("t2_en", 64'(wr_en_out), 64'd1);
        chk("t2_addr", 64'(wr_addr_out), 64'd7);
        chk("t2_data", wr_data_out, 64'hDEAD);

        // Both read ports hit the in-flight write
        rd1_addr = 5'd7; rd2_addr = 5'd7;
        #1;
        chk("t3_b1", 64'(byp1_hit), 64'd1);
        chk("t3_b2", 64'(byp2_hit), 64'd1);
        chk("t3_bd", byp_data, 64'hDEAD);
        cycle();
        chk("t3_b1_off", 64'(byp1_hit), 64'd0);
        chk("t3_b2_off", 64'(byp2_hit), 64'd0);
        chk("t3_rf", rf[7], 64'hDEAD);

        // rr_ptr is 3 after granting req 2
        v[0] = 1'b1; a[0] = 5'd9;  d[0] = 64'h9;
        v[3] = 1'b1; a[3] = 5'd10; d[3] = 64'hA;
        cycle();
        chk("t2_ptr", 64'(last_rdy), 64'b1000);
        v[3] = 1'b0;
        cycle();
        chk("t2_wrap", 64'(last_rdy), 64'b0001);
        v[0] = 1'b0;

        // wr_hold stalls new grants only
        wr_hold = 1'b1; v[1] = 1'b1; a[1] = 5'd11; d[1] = 64'hB;
        for (int s = 0; s < 3; s++) begin
            cycle();
            chk("t4_hold", 64'(last_rdy), 64'd0);
        end
        wr_hold = 1'b0;
        cycle();
        chk("t4_rel", 64'(last_rdy), 64'b0010);
        v[1] = 1'b0;

        // Write to r0 is consumed but discarded
        v[0] = 1'b1; a[0] = 5'd0; d[0] = 64'd5;
        cycle();
        chk("t5_rdy", 64'(last_rdy), 64'b0001);
        v[0] = 1'b0; rd1_addr = 5'd0; rd2_addr = 5'd0;
        #1;
        chk("t5_en", 64'(wr_en_out), 64'd0);
        chk("t5_b1", 64'(byp1_hit), 64'd0);
        cycle();

        // Reset right after a grant: write dropped, pointer cleared
        v[2] = 1'b1; a[2] = 5'd12; d[2] = 64'hAB;
        cycle();
        v[2] = 1'b0; reset = 1'b1;
        #1;
        chk("t6_en", 64'(wr_en_out), 64'd0);
        cycle();
        reset = 1'b0;
        chk("t6_rf", rf[12], 64'd0);
        v[1] = 1'b1; a[1] = 5'd13; d[1] = 64'h13;
        v[3] = 1'b1; a[3] = 5'd14; d[3] = 64'h14;
        cycle();
        chk("t6_ptr", 64'(last_rdy), 64'b0010);
        v[1] = 1'b0;

        // Randomized traffic: small address range for collisions, r0 and bypass hits
        for (int s = 0; s < 400; s++) begin
            reset   = ($urandom_range(0, 59) == 0);
            wr_hold = ($urandom_range(0, 7) == 0);
            rd1_addr = AW'($urandom_range(0, 7));
            rd2_addr = AW'($urandom_range(0, 7));
            cycle();
            for (int i = 0; i < N; i++) begin
                if (i == last_grant || !v[i]) begin
                    v[i] = ($urandom_range(0, 2) != 0);
                    a[i] = AW'($urandom_range(0, 7));
                    d[i] = {$urandom, $urandom};
                end
            end
        end
        reset = 1'b0; wr_hold = 1'b0;
        for (int i = 0; i < N; i++) v[i] = 1'b0;
        cycle();
        cycle();
        for (int r = 0; r < 32; r++) chk("rf_final", rf[r], mrf[r]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
